// File: rtl/ga_generation_ctrl.sv
// ga_generation_ctrl
// Top-level sequencer for one genetic-algorithm run. Each generation it
// evaluates the population (distance stage), then runs selection,
// crossover and mutation, and commits the new population. It stops on the
// generation limit, on reaching the target distance, on abort, or when a
// stage fails to answer within STAGE_TIMEOUT cycles.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   run, abort          run request (IDLE/ERR only), level abort
//   gen_limit           generations to evolve, latched on run
//   target_dist         early-stop distance, latched on run
//   dist_start/done     distance stage handshake; best_in valid with dist_done
//   sel_*, xov_*, mut_* selection / crossover / mutation handshakes
//   pop_we              population commit strobe
//   busy, done, error   status (done = one-cycle end pulse, error = timeout)
//   gen_count           generations committed in this/last run
//   best_dist           best distance seen in this/last run
module ga_generation_ctrl #(
    parameter int GEN_W         = 10,
    parameter int DIST_W        = 12,
    parameter int STAGE_TIMEOUT = 4096,
    parameter int TO_W          = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              abort,
    input  logic [GEN_W-1:0]  gen_limit,
    input  logic [DIST_W-1:0] target_dist,
    output logic              dist_start,
    input  logic              dist_done,
    input  logic [DIST_W-1:0] best_in,
    output logic              sel_start,
    input  logic              sel_done,
    output logic              xov_start,
    input  logic              xov_done,
    output logic              mut_start,
    input  logic              mut_done,
    output logic              pop_we,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [GEN_W-1:0]  gen_count,
    output logic [DIST_W-1:0] best_dist
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_DIST_S = 4'd1,
        ST_DIST_W = 4'd2,
        ST_SEL_S  = 4'd3,
        ST_SEL_W  = 4'd4,
        ST_XOV_S  = 4'd5,
        ST_XOV_W  = 4'd6,
        ST_MUT_S  = 4'd7,
        ST_MUT_W  = 4'd8,
        ST_COMMIT = 4'd9,
        ST_FINISH = 4'd10,
        ST_ERR    = 4'd11
    } state_t;

    localparam logic [TO_W-1:0]   WDOG_LIMIT = TO_W'(STAGE_TIMEOUT);
    localparam logic [TO_W-1:0]   WDOG_ONE   = TO_W'(1);
    localparam logic [GEN_W-1:0]  GEN_ONE    = GEN_W'(1);
    localparam logic [GEN_W-1:0]  GEN_MAX    = {GEN_W{1'b1}};
    localparam logic [DIST_W-1:0] DIST_MAX   = {DIST_W{1'b1}};

    state_t            state_q, state_d;
    logic [TO_W-1:0]   wdog_q, wdog_d;
    logic [GEN_W-1:0]  gen_q, gen_d;
    logic [GEN_W-1:0]  limit_q, limit_d;
    logic [DIST_W-1:0] best_q, best_d;
    logic [DIST_W-1:0] target_q, target_d;
    logic [DIST_W-1:0] min_s;
    logic [TO_W-1:0]   wdog_inc_s;
    logic              dist_start_q, sel_start_q, xov_start_q, mut_start_q;
    logic              pop_we_q, busy_q, done_q, error_q;

    // Next-state, watchdog and run bookkeeping.
    always_comb begin
        state_d    = state_q;
        wdog_d     = wdog_q;
        gen_d      = gen_q;
        limit_d    = limit_q;
        best_d     = best_q;
        target_d   = target_q;
        wdog_inc_s = wdog_q + WDOG_ONE;
        // Early-stop decision must see the freshly merged minimum.
        min_s      = (best_in < best_q) ? best_in : best_q;

        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (run) begin
                    limit_d  = gen_limit;
                    target_d = target_dist;
                    gen_d    = '0;
                    best_d   = DIST_MAX;
                    state_d  = ST_DIST_S;
                end else begin
                    state_d = state_q;
                end
            end
            ST_DIST_S, ST_SEL_S, ST_XOV_S, ST_MUT_S: begin
                wdog_d = '0;
                if (abort) begin
                    state_d = ST_FINISH;
                end else begin
                    // Each *_W encoding is its *_S encoding plus one.
                    state_d = state_t'(state_q + 4'd1);
                end
            end
            ST_DIST_W: begin
                wdog_d = wdog_inc_s;
                if (abort) begin
                    state_d = ST_FINISH;
                end else if (dist_done) begin
                    best_d = min_s;
                    if ((min_s <= target_q) || (gen_q == limit_q)) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_SEL_S;
                    end
                end else if (wdog_inc_s == WDOG_LIMIT) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_DIST_W;
                end
            end
            ST_SEL_W, ST_XOV_W, ST_MUT_W: begin
                wdog_d = wdog_inc_s;
                if (abort) begin
                    state_d = ST_FINISH;
                end else if ((state_q == ST_SEL_W) && sel_done) begin
                    state_d = ST_XOV_S;
                end else if ((state_q == ST_XOV_W) && xov_done) begin
                    state_d = ST_MUT_S;
                end else if ((state_q == ST_MUT_W) && mut_done) begin
                    state_d = ST_COMMIT;
                end else if (wdog_inc_s == WDOG_LIMIT) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = state_q;
                end
            end
            ST_COMMIT: begin
                // pop_we is already out this cycle, so abort still counts it.
                if (gen_q != GEN_MAX) begin
                    gen_d = gen_q + GEN_ONE;
                end else begin
                    gen_d = gen_q;
                end
                state_d = abort ? ST_FINISH : ST_DIST_S;
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wdog_q   <= '0;
            gen_q    <= '0;
            limit_q  <= '0;
            best_q   <= DIST_MAX;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            wdog_q   <= wdog_d;
            gen_q    <= gen_d;
            limit_q  <= limit_d;
            best_q   <= best_d;
            target_q <= target_d;
        end
    end

    // Moore outputs registered from the next state so they align with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dist_start_q <= 1'b0;
            sel_start_q  <= 1'b0;
            xov_start_q  <= 1'b0;
            mut_start_q  <= 1'b0;
            pop_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            dist_start_q <= (state_d == ST_DIST_S);
            sel_start_q  <= (state_d == ST_SEL_S);
            xov_start_q  <= (state_d == ST_XOV_S);
            mut_start_q  <= (state_d == ST_MUT_S);
            pop_we_q     <= (state_d == ST_COMMIT);
            busy_q       <= (state_d != ST_IDLE) && (state_d != ST_ERR);
            done_q       <= (state_d == ST_FINISH);
            error_q      <= (state_d == ST_ERR);
        end
    end

    assign dist_start = dist_start_q;
    assign sel_start  = sel_start_q;
    assign xov_start  = xov_start_q;
    assign mut_start  = mut_start_q;
    assign pop_we     = pop_we_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign gen_count  = gen_q;
    assign best_dist  = best_q;

endmodule

// File: tb/tb_ga_generation_ctrl.sv
// Directed bench for ga_generation_ctrl: stage handshakes are answered
// from the main sequence, pulse counters track start/commit/done strobes.
module tb_ga_generation_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, run, abort;
    logic [9:0]  gen_limit;
    logic [11:0] target_dist, best_in;
    logic        dist_done, sel_done, xov_done, mut_done;
    logic        dist_start, sel_start, xov_start, mut_start;
    logic        pop_we, busy, done, error;
    logic [9:0]  gen_count;
    logic [11:0] best_dist;

    int total = 0;
    int bad   = 0;
    int n_dist = 0, n_sel = 0, n_xov = 0, n_mut = 0, n_pop = 0, n_done = 0;
    int s_dist, s_sel, s_xov, s_pop, s_done;

    ga_generation_ctrl dut (
        .clk(clk), .rst_n(rst_n), .run(run), .abort(abort),
        .gen_limit(gen_limit), .target_dist(target_dist),
        .dist_start(dist_start), .dist_done(dist_done), .best_in(best_in),
        .sel_start(sel_start), .sel_done(sel_done),
        .xov_start(xov_start), .xov_done(xov_done),
        .mut_start(mut_start), .mut_done(mut_done),
        .pop_we(pop_we), .busy(busy), .done(done), .error(error),
        .gen_count(gen_count), .best_dist(best_dist)
    );

    always #5 clk = ~clk;

    // Pulse counters (each strobe is one cycle wide).
    always @(posedge clk) begin
        if (dist_start) n_dist <= n_dist + 1;
        if (sel_start)  n_sel  <= n_sel + 1;
        if (xov_start)  n_xov  <= n_xov + 1;
        if (mut_start)  n_mut  <= n_mut + 1;
        if (pop_we)     n_pop  <= n_pop + 1;
        if (done)       n_done <= n_done + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic start_of(input int w);
        case (w)
            0: return dist_start;
            1: return sel_start;
            2: return xov_start;
            3: return mut_start;
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_done(input int w, input logic v);
        case (w)
            0: dist_done = v;
            1: sel_done  = v;
            2: xov_done  = v;
            3: mut_done  = v;
            default: ;
        endcase
    endtask

    task automatic wait_start(input int w, input string tag);
        int k;
        k = 0;
        while (!start_of(w) && k < 300) begin
            tick();
            k++;
        end
        chk(tag, 32'(start_of(w)), 32'd1);
    endtask

    // Wait for a stage start, then answer 5 cycles later with a done pulse.
    task automatic serve(input int w, input logic [11:0] v, input string tag);
        wait_start(w, tag);
        repeat (4) tick();
        set_done(w, 1'b1);
        best_in = v;
        tick();
        set_done(w, 1'b0);
    endtask

    task automatic snap();
        s_dist = n_dist; s_sel = n_sel; s_xov = n_xov; s_pop = n_pop; s_done = n_done;
    endtask

    task automatic start_run(input logic [9:0] lim, input logic [11:0] tgt);
        gen_limit   = lim;
        target_dist = tgt;
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; abort = 1'b0;
        gen_limit = 10'd0; target_dist = 12'd0; best_in = 12'd0;
        dist_done = 1'b0; sel_done = 1'b0; xov_done = 1'b0; mut_done = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_gen", 32'(gen_count), 32'd0);
        chk("rst_best", 32'(best_dist), 32'hFFF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_start", 32'({dist_start, sel_start, xov_start, mut_start, pop_we}), 32'd0);

        // Run 1: three full generations, limit reached.
        snap();
        start_run(10'd3, 12'd0);
        chk("r1_latency", 32'(dist_start), 32'd1);
        chk("r1_busy", 32'(busy), 32'd1);
        serve(0, 12'd900, "r1_d0");
        serve(1, 12'd0, "r1_s0"); serve(2, 12'd0, "r1_x0"); serve(3, 12'd0, "r1_m0");
        serve(0, 12'd850, "r1_d1");
        serve(1, 12'd0, "r1_s1"); serve(2, 12'd0, "r1_x1"); serve(3, 12'd0, "r1_m1");
        serve(0, 12'd870, "r1_d2");
        serve(1, 12'd0, "r1_s2"); serve(2, 12'd0, "r1_x2"); serve(3, 12'd0, "r1_m2");
        serve(0, 12'd800, "r1_d3");
        chk("r1_done", 32'(done), 32'd1);
        tick();
        chk("r1_done_off", 32'(done), 32'd0);
        chk("r1_idle", 32'(busy), 32'd0);
        chk("r1_gen", 32'(gen_count), 32'd3);
        chk("r1_best", 32'(best_dist), 32'd800);
        chk("r1_npop", 32'(n_pop - s_pop), 32'd3);
        chk("r1_ndist", 32'(n_dist - s_dist), 32'd4);
        chk("r1_ndone", 32'(n_done - s_done), 32'd1);

        // Run 2: target reached on second evaluation; run during COMMIT ignored.
        snap();
        start_run(10'd10, 12'd500);
        serve(0, 12'd700, "r2_d0");
        serve(1, 12'd0, "r2_s0"); serve(2, 12'd0, "r2_x0"); serve(3, 12'd0, "r2_m0");
        chk("r2_commit", 32'(pop_we), 32'd1);
        gen_limit = 10'd7;
        run = 1'b1;
        tick();
        run = 1'b0;
        serve(0, 12'd450, "r2_d1");
        chk("r2_done", 32'(done), 32'd1);
        tick();
        chk("r2_gen", 32'(gen_count), 32'd1);
        chk("r2_best", 32'(best_dist), 32'd450);
        chk("r2_nsel", 32'(n_sel - s_sel), 32'd1);

        // Run 3: gen_limit = 0, single evaluation.
        snap();
        start_run(10'd0, 12'd0);
        serve(0, 12'd1000, "r3_d0");
        chk("r3_done", 32'(done), 32'd1);
        tick();
        chk("r3_gen", 32'(gen_count), 32'd0);
        chk("r3_best", 32'(best_dist), 32'd1000);
        chk("r3_nsel", 32'(n_sel - s_sel), 32'd0);
        chk("r3_ndist", 32'(n_dist - s_dist), 32'd1);

        // Run 4: crossover never answers -> watchdog timeout.
        snap();
        start_run(10'd5, 12'd0);
        serve(0, 12'd900, "r4_d0");
        serve(1, 12'd0, "r4_s0");
        wait_start(2, "r4_x0");
        tick();
        repeat (4095) tick();
        chk("r4_pre_err", 32'(error), 32'd0);
        chk("r4_pre_busy", 32'(busy), 32'd1);
        tick();
        chk("r4_err", 32'(error), 32'd1);
        chk("r4_busy", 32'(busy), 32'd0);
        chk("r4_nodone", 32'(n_done - s_done), 32'd0);
        tick();
        chk("r4_err_hold", 32'(error), 32'd1);
        chk("r4_nostart", 32'({dist_start, sel_start, xov_start, mut_start}), 32'd0);
        start_run(10'd0, 12'd0);
        chk("r4_err_clr", 32'(error), 32'd0);
        chk("r4_restart", 32'(dist_start), 32'd1);
        serve(0, 12'd1000, "r4_d1");
        tick();

        // Run 5: abort together with sel_done.
        snap();
        start_run(10'd5, 12'd0);
        serve(0, 12'd900, "r5_d0");
        wait_start(1, "r5_s0");
        repeat (4) tick();
        sel_done = 1'b1;
        abort = 1'b1;
        tick();
        sel_done = 1'b0;
        abort = 1'b0;
        chk("r5_done", 32'(done), 32'd1);
        tick();
        chk("r5_idle", 32'(busy), 32'd0);
        chk("r5_noxov", 32'(n_xov - s_xov), 32'd0);
        chk("r5_gen", 32'(gen_count), 32'd0);
        chk("r5_best", 32'(best_dist), 32'd900);

        // Run 6: spurious dones ignored, then async reset in MUT_W.
        snap();
        start_run(10'd5, 12'd0);
        chk("r6_dist_s", 32'(dist_start), 32'd1);
        dist_done = 1'b1;
        best_in = 12'd10;
        tick();
        dist_done = 1'b0;
        chk("r6_stay", 32'(sel_start), 32'd0);
        repeat (3) tick();
        dist_done = 1'b1;
        best_in = 12'd900;
        tick();
        dist_done = 1'b0;
        chk("r6_best", 32'(best_dist), 32'd900);
        wait_start(1, "r6_s0");
        tick();
        mut_done = 1'b1;
        tick();
        mut_done = 1'b0;
        chk("r6_sel_hold", 32'({xov_start, mut_start, pop_we}), 32'd0);
        sel_done = 1'b1;
        tick();
        sel_done = 1'b0;
        serve(2, 12'd0, "r6_x0");
        wait_start(3, "r6_m0");
        repeat (2) tick();
        rst_n = 1'b0;
        #2;
        chk("r6_rst_busy", 32'(busy), 32'd0);
        chk("r6_rst_best", 32'(best_dist), 32'hFFF);
        chk("r6_rst_gen", 32'(gen_count), 32'd0);
        chk("r6_rst_outs", 32'({dist_start, sel_start, xov_start, mut_start, pop_we, done, error}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("r6_post_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
